// File: rtl/seq_mult4_ctrl_pkg.sv
// seq_mult4_ctrl_pkg: shared state encoding and default operand width
package seq_mult4_ctrl_pkg;
  localparam int WIDTH_DEF = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/Prefix_Add4.sv
// Prefix_Add4: 4-bit parallel-prefix (Kogge-Stone) adder with carry in/out
module Prefix_Add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       c
);
  logic [3:0] g, p, g1, p1, g2;
  assign g = a & b;
  assign p = a ^ b;
  // level 1 folds carry-in into bit 0 and combines neighbours
  assign g1[0] = g[0] | (p[0] & cin);
  assign g1[1] = g[1] | (p[1] & g1[0]);
  assign g1[2] = g[2] | (p[2] & g[1]);
  assign g1[3] = g[3] | (p[3] & g[2]);
  assign p1    = {p[3] & p[2], p[2] & p[1], 2'b00};
  assign g2    = {g1[3] | (p1[3] & g1[1]), g1[2] | (p1[2] & g1[0]), g1[1:0]};
  assign s     = p ^ {g2[2:0], cin};
  assign c     = g2[3];
endmodule

// File: rtl/seq_mult4_ctrl.sv
// seq_mult4_ctrl: sequential shift-add unsigned multiplier sharing one adder over all rows
module seq_mult4_ctrl
  import seq_mult4_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state, state_nxt;
  logic [WIDTH-1:0] m, a, q, s, addend;
  logic [CW-1:0] cnt;
  logic c;
  assign addend = q[0] ? m : '0;
  Prefix_Add4 u_add (.a(a), .b(addend), .cin(1'b0), .s(s), .c(c));
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (in_valid ? RUN : IDLE) :
                state == RUN  ? (cnt == CW'(WIDTH - 1) ? DONE : RUN) :
                state == DONE ? (out_ready ? IDLE : DONE) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m     <= '0;
      a     <= '0;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        m   <= x;
        q   <= y;
        a   <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        a   <= {c, s[WIDTH-1:1]};
        q   <= {s[0], q[WIDTH-1:1]};
        cnt <= cnt + CW'(1);
      end
    end
  end
  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign P         = state == DONE ? {a, q} : '0;
endmodule

// File: tb/tb_seq_mult4_ctrl.sv
// tb_seq_mult4_ctrl: randomized self-checking bench against an arithmetic product model
module tb_seq_mult4_ctrl;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic [3:0] x = 0, y = 0;
  logic in_ready, out_valid, busy;
  logic [7:0] P;
  int n_cmp = 0, n_bad = 0;

  seq_mult4_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .out_valid(out_valid), .out_ready(out_ready), .P(P), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [3:0] a, input logic [3:0] b);
    return 8'(int'(a) * int'(b));
  endfunction

  // accept one operand pair from IDLE and wait (bounded) for out_valid; lat counts edges after accept
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, output logic [7:0] p, output int lat);
    in_valid = 1; x = a; y = b;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    p = P;
  endtask

  task automatic finish_op();
    out_ready = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready_during_rst got=%b want=0", in_ready); end
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 8'd0 || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d got in_ready=%b out_valid=%b P=%0d busy=%b want 1 0 0 0", i, in_ready, out_valid, P, busy);
      end
    end
  endtask

  task automatic test_basic();
    logic [7:0] p;
    int lat;
    out_ready = 1;
    do_op(4'd13, 4'd11, p, lat);
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    n_cmp++; if (p !== 8'd143) begin n_bad++; $display("FAIL basic_product got=%0d want=143", p); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_done_flags got in_ready=%b busy=%b want 0 1", in_ready, busy); end
    finish_op();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 8'd0) begin
      n_bad++;
      $display("FAIL basic_return_idle got in_ready=%b out_valid=%b P=%0d want 1 0 0", in_ready, out_valid, P);
    end
  endtask

  task automatic test_corners();
    logic [3:0] xs [5] = '{4'd15, 4'd0, 4'd9, 4'd1, 4'd8};
    logic [3:0] ys [5] = '{4'd15, 4'd9, 4'd0, 4'd1, 4'd2};
    logic [7:0] p;
    int lat;
    for (int i = 0; i < 5; i++) begin
      do_op(xs[i], ys[i], p, lat);
      n_cmp++;
      if (p !== model(xs[i], ys[i]) || lat !== 4) begin
        n_bad++;
        $display("FAIL corner %0d*%0d got P=%0d lat=%0d want P=%0d lat=4", xs[i], ys[i], p, lat, model(xs[i], ys[i]));
      end
      finish_op();
    end
  endtask

  task automatic test_sweep();
    logic [7:0] p;
    int lat, bad_here;
    bad_here = 0;
    out_ready = 1;
    for (int i = 0; i < 256; i++) begin
      do_op(4'(i >> 4), 4'(i), p, lat);
      n_cmp++;
      if (p !== model(4'(i >> 4), 4'(i)) || lat !== 4) begin
        n_bad++;
        if (bad_here++ < 8) $display("FAIL sweep %0d*%0d got P=%0d lat=%0d want P=%0d", i >> 4, i & 15, p, lat, model(4'(i >> 4), 4'(i)));
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] p;
    int lat;
    out_ready = 0;
    do_op(4'd6, 4'd7, p, lat);
    n_cmp++; if (p !== 8'd42) begin n_bad++; $display("FAIL bp_product got=%0d want=42", p); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; x = 4'd3; y = 4'd3;
      @(posedge clk); #1;
      n_cmp++;
      if (P !== 8'd42 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_stall cyc=%0d got P=%0d out_valid=%b in_ready=%b want 42 1 0", i, P, out_valid, in_ready);
      end
    end
    in_valid = 0;
    finish_op();
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got busy=%b in_ready=%b out_valid=%b want 0 1 0", busy, in_ready, out_valid);
    end
  endtask

  task automatic test_input_stability();
    int lat;
    out_ready = 1;
    in_valid = 1; x = 4'd5; y = 4'd10;
    @(posedge clk); #1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = 1'($urandom); x = 4'($urandom); y = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 0;
    n_cmp++;
    if (P !== 8'd50 || lat !== 4) begin
      n_bad++;
      $display("FAIL stability got P=%0d lat=%0d want P=50 lat=4", P, lat);
    end
    finish_op();
  endtask

  task automatic test_reset_mid();
    logic [7:0] p;
    int lat;
    out_ready = 1;
    in_valid = 1; x = 4'd12; y = 4'd12;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || P !== 8'd0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid got out_valid=%b busy=%b P=%0d in_ready=%b want 0 0 0 0", out_valid, busy, P, in_ready);
    end
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mid_idle got in_ready=%b want 1", in_ready); end
    do_op(4'd2, 4'd3, p, lat);
    n_cmp++;
    if (p !== 8'd6 || lat !== 4) begin
      n_bad++;
      $display("FAIL reset_mid_next got P=%0d lat=%0d want P=6 lat=4", p, lat);
    end
    finish_op();
  endtask

  // random operands with random consumer stalls; back-to-back accepts as soon as in_ready returns
  task automatic test_back_to_back();
    logic [3:0] a, b;
    logic [7:0] p;
    int lat, stall;
    for (int t = 0; t < 40; t++) begin
      a = 4'($urandom); b = 4'($urandom);
      stall = int'($urandom_range(0, 3));
      out_ready = (stall == 0);
      do_op(a, b, p, lat);
      n_cmp++;
      if (p !== model(a, b) || lat !== 4) begin
        n_bad++;
        $display("FAIL b2b t=%0d %0d*%0d got P=%0d lat=%0d want P=%0d", t, a, b, p, lat, model(a, b));
      end
      for (int k = 0; k < stall; k++) begin
        @(posedge clk); #1;
        n_cmp++;
        if (P !== model(a, b) || out_valid !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_hold t=%0d got P=%0d out_valid=%b want P=%0d 1", t, P, out_valid, model(a, b));
        end
      end
      finish_op();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready t=%0d got=%b want=1", t, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_sweep();
    test_backpressure();
    test_input_stability();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
